// File: rtl/telem_packetizer.sv
// Telemetry packetizer: reads a contiguous window of sensor registers and
// streams SYNC, SEQ, payload bytes and a two's-complement checksum over a
// valid/ready byte interface. One packet per accepted start pulse.
module telem_packetizer #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter logic [7:0] FIRST_ADDR = 8'd1,
    parameter logic [7:0] LAST_ADDR  = 8'd25
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       start_drop
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        ADDR,
        CAPTURE,
        PAYLOAD,
        CHK
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] seq_reg,   seq_next;
    logic [7:0] acc_reg,   acc_next;
    logic [7:0] addr_reg,  addr_next;
    logic [7:0] data_reg,  data_next;
    logic       drop_reg,  drop_next;

    // State and datapath registers; rst low forces everything to idle values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            seq_reg   <= 8'h00;
            acc_reg   <= 8'h00;
            addr_reg  <= 8'h00;
            data_reg  <= 8'h00;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            seq_reg   <= seq_next;
            acc_reg   <= acc_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            drop_reg  <= drop_next;
        end
    end

    // Next-state, datapath updates and byte-stream outputs.
    always_comb begin
        state_next = state_reg;
        seq_next   = seq_reg;
        acc_next   = acc_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        busy       = (state_reg != IDLE);
        // A start seen in any non-idle state (including the CHK transfer
        // cycle) is discarded and flagged; nothing is queued.
        drop_next  = start && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                addr_next = 8'h00;
                if (start) begin
                    acc_next   = 8'h00;
                    state_next = SYNC;
                end
            end
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_next = SEQ;
                end
            end
            SEQ: begin
                tx_valid = 1'b1;
                tx_data  = seq_reg;
                if (tx_ready) begin
                    acc_next   = acc_reg + seq_reg;
                    addr_next  = FIRST_ADDR;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                // reg_addr settles for a cycle before the register file is sampled.
                state_next = CAPTURE;
            end
            CAPTURE: begin
                // Freeze the byte here so later reg_data changes cannot leak out.
                data_next  = reg_data;
                state_next = PAYLOAD;
            end
            PAYLOAD: begin
                tx_valid = 1'b1;
                tx_data  = data_reg;
                if (tx_ready) begin
                    acc_next = acc_reg + data_reg;
                    if (addr_reg == LAST_ADDR) begin
                        state_next = CHK;
                    end else begin
                        addr_next  = addr_reg + 8'd1;
                        state_next = ADDR;
                    end
                end
            end
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = ~acc_reg + 8'd1;
                if (tx_ready) begin
                    seq_next   = seq_reg + 8'd1;
                    addr_next  = 8'h00;
                    state_next = IDLE;
                end
            end
            default: begin
                addr_next  = 8'h00;
                state_next = IDLE;
            end
        endcase
    end

    assign reg_addr   = addr_reg;
    assign start_drop = drop_reg;

endmodule

// File: tb/tb_telem_packetizer.sv
// Bench for telem_packetizer: table of packet vectors plus hand-written
// overlap, reset-abort, capture-freeze and sequence-wrap sequences.
module tb_telem_packetizer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic       start_drop;

    int         dmode = 0;
    bit         rnd_ready = 1'b0;
    bit         hold_ready = 1'b0;
    bit         ovr_en = 1'b0;
    logic [7:0] ovr_val = 8'h00;

    logic [7:0] sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         drop_cnt = 0;
    bit         last_rst = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    typedef struct {
        string      name;
        int         mode;
        bit         rnd;
        logic [7:0] seq;
        logic [7:0] chk;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    // Sensor register file model: payload depends on the address and mode.
    function automatic logic [7:0] pay(input int mode, input logic [7:0] a);
        case (mode)
            0:       return a;
            1:       return ~a;
            default: return 8'h00;
        endcase
    endfunction

    assign reg_data = ovr_en ? ovr_val : pay(dmode, reg_addr);

    telem_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .start_drop (start_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Negedge observation of the edge about to happen (inputs are final here).
    task automatic monitor();
        logic [7:0] exp;
        if (!last_rst) begin
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_valid", {31'd0, tx_valid}, 32'd0);
            check("rst_data", {24'd0, tx_data}, 32'd0);
            check("rst_addr", {24'd0, reg_addr}, 32'd0);
            check("rst_drop", {31'd0, start_drop}, 32'd0);
        end else if (prev_stall) begin
            check("hold_valid", {31'd0, tx_valid}, 32'd1);
            check("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (start_drop) drop_cnt++;
        if (rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_byte: got %0h expected no byte", tx_data);
            end else begin
                exp = sb.pop_front();
                check("byte", {24'd0, tx_data}, {24'd0, exp});
            end
        end
        prev_stall = rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
        last_rst   = rst;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        tx_ready = hold_ready ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    endtask

    task automatic begin_packet(input logic [7:0] seq, input logic [7:0] chk, input int mode, input bit rnd);
        dmode     = mode;
        rnd_ready = rnd;
        sb.push_back(8'hA5);
        sb.push_back(seq);
        for (int a = 1; a <= 25; a++) sb.push_back(pay(mode, 8'(a)));
        sb.push_back(chk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_left"}, sb.size(), 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n;
        logic [7:0] s;
        logic [7:0] c;

        vecs[0] = '{name: "addr_ready",  mode: 0, rnd: 1'b0, seq: 8'h00, chk: 8'hBB};
        vecs[1] = '{name: "addr_bp",     mode: 0, rnd: 1'b1, seq: 8'h01, chk: 8'hBA};
        vecs[2] = '{name: "inv_ready",   mode: 1, rnd: 1'b0, seq: 8'h02, chk: 8'h5C};
        vecs[3] = '{name: "zero_bp",     mode: 2, rnd: 1'b1, seq: 8'h03, chk: 8'hFD};

        // Reset with start held: must be ignored, no drop pulse.
        rst   = 1'b0;
        start = 1'b1;
        wait_cycles(3);
        start = 1'b0;
        rst   = 1'b1;
        tick();
        check("post_rst_drop_cnt", drop_cnt, 32'd0);

        for (int i = 0; i < 4; i++) begin
            begin_packet(vecs[i].seq, vecs[i].chk, vecs[i].mode, vecs[i].rnd);
            wait_done(vecs[i].name);
            $display("packet %s seq %02h done", vecs[i].name, vecs[i].seq);
        end
        rnd_ready = 1'b0;

        // Overlap: starts during payload byte 10 and in the CHK transfer cycle.
        drop_cnt = 0;
        begin_packet(8'h04, 8'hB7, 0, 1'b0);
        n = 0;
        while (!(tx_valid && reg_addr == 8'd10) && n < 500) begin tick(); n++; end
        check("ovl_addr", {24'd0, reg_addr}, 32'd10);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(tx_valid && sb.size() == 1) && n < 500) begin tick(); n++; end
        check("ovl_chk_left", sb.size(), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("overlap");
        wait_cycles(4);
        check("ovl_busy", {31'd0, busy}, 32'd0);
        check("ovl_drops", drop_cnt, 32'd2);
        $display("packet overlap seq 04 done, drops %0d", drop_cnt);

        // Reset after payload byte 5: partial packet, no CHK.
        dmode = 0;
        sb.push_back(8'hA5);
        sb.push_back(8'h05);
        for (int a = 1; a <= 5; a++) sb.push_back(8'(a));
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 500) begin tick(); n++; end
        check("abort_left", sb.size(), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("abort_busy", {31'd0, busy}, 32'd0);
        begin_packet(8'h00, 8'hBB, 0, 1'b0);
        wait_done("after_abort");
        $display("packet after_abort seq 00 done");

        // Capture freeze: reg_data changes while payload byte 3 is stalled.
        begin_packet(8'h01, 8'hBA, 0, 1'b0);
        n = 0;
        while (reg_addr != 8'd3 && n < 500) begin tick(); n++; end
        hold_ready = 1'b1;
        tx_ready   = 1'b0;
        n = 0;
        while (!tx_valid && n < 20) begin tick(); n++; end
        check("frz_valid", {31'd0, tx_valid}, 32'd1);
        ovr_en  = 1'b1;
        ovr_val = 8'hEE;
        wait_cycles(3);
        hold_ready = 1'b0;
        tx_ready   = 1'b1;
        tick();
        ovr_en = 1'b0;
        wait_done("freeze");
        $display("packet freeze seq 01 done");

        // Sequence wrap: 257 zero-payload packets from a fresh reset.
        rst = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 257; i++) begin
            s = 8'(i);
            c = 8'h00 - s;
            if (i == 255) begin s = 8'hFF; c = 8'h01; end
            if (i == 256) begin s = 8'h00; c = 8'h00; end
            begin_packet(s, c, 2, 1'b0);
            wait_done("wrap");
            if (i >= 254) $display("packet wrap %0d seq %02h done", i + 1, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/telem_packetizer.md
TELEM_PACKETIZER -- requirements
Module: telem_packetizer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every packet.
REQ-002 SHALL have parameter FIRST_ADDR, default 8'd1, first sensor-register address read.
REQ-003 SHALL have parameter LAST_ADDR, default 8'd25, last sensor-register address read.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-low (asserted when 0).
REQ-006 SHALL have port start  input  1  one-cycle request to send one packet.
REQ-007 SHALL have port reg_addr  output  8  address driven to the sensor register file.
REQ-008 SHALL have port reg_data  input  8  byte returned combinationally for reg_addr.
REQ-009 SHALL have port tx_data  output  8  outgoing packet byte.
REQ-010 SHALL have port tx_valid  output  1  tx_data holds a valid byte.
REQ-011 SHALL have port tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-012 SHALL have port busy  output  1  packet in progress.
REQ-013 SHALL have port start_drop  output  1  one-cycle pulse when start is ignored.

Function
REQ-014 Packet SHALL be: SYNC_BYTE, SEQ, payload bytes for FIRST_ADDR..LAST_ADDR in ascending order, CHK (28 bytes with defaults).
REQ-015 A byte SHALL transfer on a rising edge where tx_valid=1 and tx_ready=1.
REQ-016 While tx_valid=1 and tx_ready=0, tx_data SHALL stay stable.
REQ-017 While tx_valid=1, tx_valid SHALL remain 1 until the byte transfers.
REQ-018 FSM states SHALL be IDLE, SYNC, SEQ, ADDR, CAPTURE, PAYLOAD, CHK.
REQ-019 IDLE: busy=0, tx_valid=0, reg_addr=0. start=1 -> SYNC on the next edge.
REQ-020 SYNC: tx_data=SYNC_BYTE, tx_valid=1. On transfer -> SEQ.
REQ-021 SEQ: tx_data=seq counter, tx_valid=1. On transfer -> ADDR, with reg_addr=FIRST_ADDR.
REQ-022 ADDR: tx_valid=0, reg_addr held for one settling cycle -> CAPTURE.
REQ-023 CAPTURE: reg_data is registered into tx_data -> PAYLOAD.
REQ-024 PAYLOAD: tx_valid=1. On transfer:
- if reg_addr=LAST_ADDR -> CHK;
- otherwise reg_addr increments by 1 -> ADDR.
REQ-025 The payload byte SHALL be frozen at CAPTURE; later changes on reg_data SHALL NOT alter the byte already presented.
REQ-026 The checksum accumulator SHALL be 8-bit, modulo 256:
- cleared at SYNC entry;
- adds SEQ and every payload byte as each transfers.
REQ-027 CHK: tx_data = two's complement of the accumulator, so SEQ+payload+CHK = 0 mod 256; tx_valid=1.
REQ-028 On CHK transfer, seq SHALL increment (255 wraps to 0) and the FSM SHALL return to IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 start while busy=1 (including the cycle CHK transfers) SHALL be ignored and pulse start_drop for one cycle.
REQ-031 No request SHALL queue.
REQ-032 Minimum packet duration with tx_ready held 1 SHALL be 2 + 3*N + 1 cycles from the SYNC state, N = LAST_ADDR-FIRST_ADDR+1 (78 cycles with defaults).

Reset
REQ-033 While rst=0 at a rising edge:
- state=IDLE, seq=0, accumulator=0;
- tx_data=0, tx_valid=0, reg_addr=0, busy=0, start_drop=0.
REQ-034 Reset mid-packet SHALL abort the packet immediately, with no CHK byte sent.
REQ-035 start asserted together with rst=0 SHALL be ignored without a start_drop pulse.

Verification
REQ-036 Byte stream: reg_data=reg_addr, tx_ready=1, one start pulse -> 28 bytes:
- A5, 00, 01..19 (hex), BB;
- busy then falls and seq reads 1.
REQ-037 Backpressure: same stimulus, tx_ready toggling pseudo-randomly -> identical 28-byte stream; tx_data never changes while tx_valid=1 and tx_ready=0.
REQ-038 Sequence wrap: 256 packets with reg_data=0 -> packet 256 carries SEQ=FF, CHK=01; packet 257 carries SEQ=00, CHK=00.
REQ-039 Overlap: start pulsed during payload byte 10 and again in the CHK-transfer cycle -> start_drop pulses twice, exactly one packet sent.
REQ-040 Reset mid-packet: rst=0 for one cycle after payload byte 5 -> all outputs and seq at reset values; next start -> packet with SEQ=00.
REQ-041 Capture freeze: reg_data changed while PAYLOAD is stalled with tx_ready=0 -> transmitted byte equals the value captured at CAPTURE.
